// File: rtl/aes_encrypt_core_param.sv
// aes_encrypt_core_param: iterative AES-128/AES-256 encryption, one round per clock, on-the-fly key expansion.
// Latency: NR cycles (10 or 14) from the accept edge to cipher_ready; one block every NR+1 cycles.
// Backpressure: none; cipher_new_en is taken only while cipher_busy=0, requests during rounds are dropped.
// Ports: clk, reset (async, active-high); plain_text, cipher_key, cipher_new_en in;
//        cipher_busy, cipher_ready, cipher_text out; last_round_key out (round key NR) when enabled.
// Optional feature macro: AES_LAST_KEY_OUT_EN adds last_round_key for decrypt-core key setup.

module aes_encrypt_core_param #(
   parameter int KEY_BITS = 128
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [127:0]        plain_text,
   input  logic [KEY_BITS-1:0] cipher_key,
   input  logic                cipher_new_en,
   output logic                cipher_busy,
   output logic                cipher_ready,
   output logic [127:0]        cipher_text
`ifdef AES_LAST_KEY_OUT_EN
   ,
   output logic [127:0]        last_round_key
`endif
);

   localparam int         NR     = (KEY_BITS == 256) ? 14 : 10;
   localparam logic [3:0] LAST_R = 4'(NR);

   generate
      if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
         $error("aes_encrypt_core_param: KEY_BITS must be 128 or 256");
      end
   endgenerate

   // Forward S-box, entry 0 in the top byte.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[{~b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] k);
      case (k)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   // Chains the four words of the older key with the mixed last word.
   function automatic logic [127:0] expand(input logic [127:0] prev, input logic [31:0] temp);
      logic [31:0] w0, w1, w2, w3;
      w0 = prev[127:96] ^ temp;
      w1 = prev[95:64]  ^ w0;
      w2 = prev[63:32]  ^ w1;
      w3 = prev[31:0]   ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // SubBytes + ShiftRows + (optional) MixColumns; byte i sits at row i%4, column i/4.
   function automatic logic [127:0] sub_shift_mix(input logic [127:0] s, input logic last);
      logic [7:0]   sb [16];
      logic [7:0]   sh [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] o;
      o = '0;
      for (int i = 0; i < 16; i++) sb[i] = sbox(s[127-8*i -: 8]);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            sh[4*c+r] = sb[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++) begin
         a0 = sh[4*c];
         a1 = sh[4*c+1];
         a2 = sh[4*c+2];
         a3 = sh[4*c+3];
         if (last) o[127-32*c -: 32] = {a0, a1, a2, a3};
         else o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                   a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                   a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                   xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
      end
      return o;
   endfunction

   fsm_t         fsm_q, fsm_d;
   logic [127:0] blk_q, blk_d;
   logic [127:0] key_a_q, key_a_d;   // AES-128: key r-1; AES-256: key r-2
   logic [127:0] key_b_q, key_b_d;   // AES-256 only: key r-1 (stays 0 for AES-128)
   logic [3:0]   round_q, round_d;
   logic         busy_q, busy_d;
   logic         ready_q, ready_d;
   logic [127:0] text_q, text_d;
`ifdef AES_LAST_KEY_OUT_EN
   logic [127:0] last_key_q, last_key_d;
`endif

   logic [255:0] key_w;   // cipher key left-justified: first 128 key bits in [255:128]
   logic [31:0]  temp;
   logic [127:0] rk, rnd;
   logic         last;

   assign key_w = 256'(cipher_key) << (256 - KEY_BITS);

   always_comb begin
      fsm_d   = fsm_q;
      blk_d   = blk_q;
      key_a_d = key_a_q;
      key_b_d = key_b_q;
      round_d = round_q;
      busy_d  = busy_q;
      ready_d = ready_q;
      text_d  = text_q;
`ifdef AES_LAST_KEY_OUT_EN
      last_key_d = last_key_q;
`else
      // Round key NR is not retained in this build.
`endif
      temp = '0;
      last = (round_q == LAST_R);

      // Round key r for the round being applied on this edge.
      if (KEY_BITS == 128) begin
         temp = sub_word(rot_word(key_a_q[31:0])) ^ {rcon(round_q), 24'h0};
         rk   = expand(key_a_q, temp);
      end else if (round_q == 4'd1) begin
         rk = key_b_q;   // second half of the cipher key is used as-is
      end else begin
         if (!round_q[0]) temp = sub_word(rot_word(key_b_q[31:0])) ^ {rcon({1'b0, round_q[3:1]}), 24'h0};
         else             temp = sub_word(key_b_q[31:0]);
         rk = expand(key_a_q, temp);
      end
      rnd = sub_shift_mix(blk_q, last) ^ rk;

      case (fsm_q)
         ROUND: begin
            blk_d   = rnd;
            round_d = round_q + 4'd1;
            if (KEY_BITS == 128) begin
               key_a_d = rk;
            end else if (round_q != 4'd1) begin
               key_a_d = key_b_q;
               key_b_d = rk;
            end
            if (last) begin
               text_d  = rnd;
               ready_d = 1'b1;
               busy_d  = 1'b0;
               fsm_d   = DONE;
`ifdef AES_LAST_KEY_OUT_EN
               last_key_d = rk;
`endif
            end
         end
         default: begin   // IDLE and DONE both accept a new request
            if (cipher_new_en) begin
               blk_d   = plain_text ^ key_w[255:128];
               key_a_d = key_w[255:128];
               key_b_d = key_w[127:0];
               round_d = 4'd1;
               ready_d = 1'b0;
               busy_d  = 1'b1;
               fsm_d   = ROUND;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm_q   <= IDLE;
         blk_q   <= '0;
         key_a_q <= '0;
         key_b_q <= '0;
         round_q <= '0;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
         text_q  <= '0;
`ifdef AES_LAST_KEY_OUT_EN
         last_key_q <= '0;
`endif
      end else begin
         fsm_q   <= fsm_d;
         blk_q   <= blk_d;
         key_a_q <= key_a_d;
         key_b_q <= key_b_d;
         round_q <= round_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
         text_q  <= text_d;
`ifdef AES_LAST_KEY_OUT_EN
         last_key_q <= last_key_d;
`endif
      end
   end

   assign cipher_busy  = busy_q;
   assign cipher_ready = ready_q;
   assign cipher_text  = text_q;
`ifdef AES_LAST_KEY_OUT_EN
   assign last_round_key = last_key_q;
`endif

endmodule

// File: tb/tb_aes_encrypt_core_param.sv
// tb_aes_encrypt_core_param: checks AES-128 and AES-256 instances against a FIPS-197 style model.
// Latency: expects cipher_ready exactly NR cycles after accept, busy for exactly NR cycles.
// Backpressure: requests pulsed during rounds must be ignored.

module tb_aes_encrypt_core_param;

   localparam logic [127:0] FIPS_PT   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_K128 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [255:0] FIPS_K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

   logic         clk = 1'b0;
   logic         reset;
   logic [127:0] pt_a, pt_b;
   logic [127:0] key_a;
   logic [255:0] key_b;
   logic         en_a, en_b;
   logic         busy_a, busy_b, ready_a, ready_b;
   logic [127:0] text_a, text_b;
`ifdef AES_LAST_KEY_OUT_EN
   logic [127:0] lrk_a, lrk_b;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] sbox_m [256];

   always #5 clk = ~clk;

   aes_encrypt_core_param #(.KEY_BITS(128)) u_dut128 (
      .clk(clk), .reset(reset), .plain_text(pt_a), .cipher_key(key_a), .cipher_new_en(en_a),
      .cipher_busy(busy_a), .cipher_ready(ready_a), .cipher_text(text_a)
`ifdef AES_LAST_KEY_OUT_EN
      , .last_round_key(lrk_a)
`endif
   );

   aes_encrypt_core_param #(.KEY_BITS(256)) u_dut256 (
      .clk(clk), .reset(reset), .plain_text(pt_b), .cipher_key(key_b), .cipher_new_en(en_b),
      .cipher_busy(busy_b), .cipher_ready(ready_b), .cipher_text(text_b)
`ifdef AES_LAST_KEY_OUT_EN
      , .last_round_key(lrk_b)
`endif
   );

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      logic       hi;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         hi = x[7];
         x  = {x[6:0], 1'b0};
         if (hi) x = x ^ 8'h1b;
         y = {1'b0, y[7:1]};
      end
      return p;
   endfunction

   task automatic build_sbox();
      logic [7:0] b;
      for (int x = 0; x < 256; x++) begin
         b = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
         sbox_m[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] sub_word_m(input logic [31:0] w);
      return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
   endfunction

   function automatic logic [7:0] rcon_m(input int n);
      logic [7:0] x;
      x = 8'h01;
      for (int j = 1; j < n; j++) x = gmul(x, 8'h02);
      return x;
   endfunction

   // Full key expansion up front, then the textbook round sequence on a byte array.
   task automatic aes_ref(input logic [127:0] pt, input logic [255:0] key, input int nk,
                          output logic [127:0] ct, output logic [127:0] lrk);
      logic [31:0] w [60];
      logic [7:0]  s [16];
      logic [7:0]  t [16];
      logic [7:0]  a [4];
      logic [31:0] tmp;
      int          nr;
      nr = nk + 6;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         tmp = w[i-1];
         if (i % nk == 0) tmp = sub_word_m({tmp[23:0], tmp[31:24]}) ^ {rcon_m(i/nk), 24'h0};
         else if (nk > 6 && i % nk == 4) tmp = sub_word_m(tmp);
         w[i] = w[i-nk] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
      for (int rd = 0; rd <= nr; rd++) begin
         if (rd > 0) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_m[s[i]];
            for (int c = 0; c < 4; c++)
               for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
            s = t;
            if (rd < nr) begin
               for (int c = 0; c < 4; c++) begin
                  for (int r = 0; r < 4; r++) a[r] = s[4*c+r];
                  s[4*c]   = gmul(8'h02, a[0]) ^ gmul(8'h03, a[1]) ^ a[2] ^ a[3];
                  s[4*c+1] = a[0] ^ gmul(8'h02, a[1]) ^ gmul(8'h03, a[2]) ^ a[3];
                  s[4*c+2] = a[0] ^ a[1] ^ gmul(8'h02, a[2]) ^ gmul(8'h03, a[3]);
                  s[4*c+3] = gmul(8'h03, a[0]) ^ a[1] ^ a[2] ^ gmul(8'h02, a[3]);
               end
            end
         end
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[4*rd+c][31-8*r -: 8];
      end
      for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
      lrk = {w[4*nr], w[4*nr+1], w[4*nr+2], w[4*nr+3]};
   endtask

   // ---------------- access helpers ----------------
   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic drive(input bit sel, input logic en, input logic [127:0] pt, input logic [255:0] key);
      if (sel) begin en_b = en; pt_b = pt; key_b = key; end
      else begin en_a = en; pt_a = pt; key_a = key[255:128]; end
   endtask

   function automatic logic obs_busy(input bit sel);
      return sel ? busy_b : busy_a;
   endfunction
   function automatic logic obs_ready(input bit sel);
      return sel ? ready_b : ready_a;
   endfunction
   function automatic logic [127:0] obs_text(input bit sel);
      return sel ? text_b : text_a;
   endfunction
`ifdef AES_LAST_KEY_OUT_EN
   function automatic logic [127:0] obs_lrk(input bit sel);
      return sel ? lrk_b : lrk_a;
   endfunction
`endif

   // One operation from the current negedge; glitch >= 0 pulses a bogus request at that cycle.
   task automatic run_op(input bit sel, input logic [127:0] pt, input logic [255:0] key,
                         input int glitch, input string name);
      logic [127:0] exp_ct, exp_lrk, prev;
      int nr, lat, bcnt;
      nr = sel ? 14 : 10;
      aes_ref(pt, key, sel ? 8 : 4, exp_ct, exp_lrk);
      prev = obs_text(sel);
      drive(sel, 1'b1, pt, key);
      @(negedge clk);
      drive(sel, 1'b0, rand128(), {rand128(), rand128()});
      n_checks++;
      if (obs_busy(sel) !== 1'b1 || obs_ready(sel) !== 1'b0 || obs_text(sel) !== prev) begin
         n_fail++;
         $display("FAIL %s_accept: busy=%b ready=%b text=%h, required busy=1 ready=0 text=%h",
                  name, obs_busy(sel), obs_ready(sel), obs_text(sel), prev);
      end
      lat  = 0;
      bcnt = 1;
      while (obs_ready(sel) !== 1'b1 && lat < 60) begin
         drive(sel, (lat == glitch) ? 1'b1 : 1'b0, rand128(), {rand128(), rand128()});
         @(negedge clk);
         lat++;
         if (obs_busy(sel) === 1'b1) bcnt++;
      end
      drive(sel, 1'b0, rand128(), {rand128(), rand128()});
      n_checks++;
      if (lat !== nr) begin
         n_fail++;
         $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat, nr);
      end
      n_checks++;
      if (bcnt !== nr) begin
         n_fail++;
         $display("FAIL %s_busy_cycles: got %0d, required %0d", name, bcnt, nr);
      end
      n_checks++;
      if (obs_text(sel) !== exp_ct || obs_busy(sel) !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_result: text=%h busy=%b, required text=%h busy=0",
                  name, obs_text(sel), obs_busy(sel), exp_ct);
      end
`ifdef AES_LAST_KEY_OUT_EN
      n_checks++;
      if (obs_lrk(sel) !== exp_lrk) begin
         n_fail++;
         $display("FAIL %s_last_key: got %h, required %h", name, obs_lrk(sel), exp_lrk);
      end
`endif
   endtask

   task automatic check_text(input bit sel, input logic [127:0] exp, input string name);
      n_checks++;
      if (obs_text(sel) !== exp || obs_ready(sel) !== 1'b1) begin
         n_fail++;
         $display("FAIL %s: text=%h ready=%b, required text=%h ready=1",
                  name, obs_text(sel), obs_ready(sel), exp);
      end
   endtask

   task automatic check_zero(input bit sel, input string name);
      n_checks++;
      if (obs_busy(sel) !== 1'b0 || obs_ready(sel) !== 1'b0 || obs_text(sel) !== 128'h0) begin
         n_fail++;
         $display("FAIL %s: busy=%b ready=%b text=%h, required all zero",
                  name, obs_busy(sel), obs_ready(sel), obs_text(sel));
      end
`ifdef AES_LAST_KEY_OUT_EN
      n_checks++;
      if (obs_lrk(sel) !== 128'h0) begin
         n_fail++;
         $display("FAIL %s_last_key: got %h, required 0", name, obs_lrk(sel));
      end
`endif
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      check_zero(1'b0, "reset_aes128");
      check_zero(1'b1, "reset_aes256");
   endtask

   task automatic test_aes128_vector();
      run_op(1'b0, FIPS_PT, {FIPS_K128, 128'h0}, -1, "aes128_fips");
      check_text(1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, "aes128_fips_const");
`ifdef AES_LAST_KEY_OUT_EN
      n_checks++;
      if (lrk_a !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin
         n_fail++;
         $display("FAIL aes128_last_key_const: got %h, required 13111d7fe3944a17f307a78b4d2b30c5", lrk_a);
      end
`endif
   endtask

   task automatic test_aes256_vector();
      run_op(1'b1, FIPS_PT, FIPS_K256, -1, "aes256_fips");
      check_text(1'b1, 128'h8ea2b7ca516745bfeafc49904b496089, "aes256_fips_const");
   endtask

   task automatic test_back_to_back();
      run_op(1'b0, 128'h0, 256'h0, -1, "b2b_zero");
      check_text(1'b0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, "b2b_zero_const");
      run_op(1'b0, FIPS_PT, {{16{8'ha5}}, 128'h0}, -1, "b2b_second");
   endtask

   task automatic test_ignore_busy();
      run_op(1'b0, FIPS_PT, {FIPS_K128, 128'h0}, 4, "ignore_aes128");
      check_text(1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, "ignore_aes128_const");
      run_op(1'b1, FIPS_PT, FIPS_K256, 9, "ignore_aes256");
      check_text(1'b1, 128'h8ea2b7ca516745bfeafc49904b496089, "ignore_aes256_const");
   endtask

   task automatic test_hold();
      logic [127:0] ta, tb;
      ta = text_a;
      tb = text_b;
      repeat (20) @(negedge clk);
      n_checks++;
      if (text_a !== ta || ready_a !== 1'b1 || busy_a !== 1'b0 ||
          text_b !== tb || ready_b !== 1'b1 || busy_b !== 1'b0) begin
         n_fail++;
         $display("FAIL done_hold: a=%h/%b/%b b=%h/%b/%b, required a=%h/1/0 b=%h/1/0",
                  text_a, ready_a, busy_a, text_b, ready_b, busy_b, ta, tb);
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b0, 1'b1, rand128(), {rand128(), 128'h0});
      drive(1'b1, 1'b1, rand128(), {rand128(), rand128()});
      @(negedge clk);
      drive(1'b0, 1'b0, rand128(), 256'h0);
      drive(1'b1, 1'b0, rand128(), 256'h0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      check_zero(1'b0, "mid_reset_aes128");
      check_zero(1'b1, "mid_reset_aes256");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_zero(1'b0, "mid_reset_idle_aes128");
      run_op(1'b0, FIPS_PT, {FIPS_K128, 128'h0}, -1, "after_reset_aes128");
      check_text(1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, "after_reset_const");
   endtask

   task automatic test_random();
      for (int i = 0; i < 4; i++) begin
         run_op(1'b0, rand128(), {rand128(), 128'h0}, int'($urandom_range(0, 12)) - 2, "rand_aes128");
         run_op(1'b1, rand128(), {rand128(), rand128()}, int'($urandom_range(0, 16)) - 2, "rand_aes256");
      end
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 1'b0, 128'h0, 256'h0);
      drive(1'b1, 1'b0, 128'h0, 256'h0);
      build_sbox();
      repeat (3) @(negedge clk);
      test_reset();
      reset = 1'b0;
      @(negedge clk);
      test_aes128_vector();
      test_aes256_vector();
      test_back_to_back();
      test_ignore_busy();
      test_hold();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_encrypt_core_param.md
# aes_encrypt_core_param

Iterative AES encryption core, parametrised for AES-128 or AES-256 key length, computing one round per clock with on-the-fly key expansion. It generalises the existing fixed AES-128 encrypt top with a selectable key size, an explicit busy indication and defined request/result rules. It reuses the codebase's S-box, ShiftRow, Rcon and Mul functions. It sits between the block-cipher mode logic (upstream request source) and the result consumer.

## Interface
- KEY_BITS, 128, cipher key width; legal values 128 (NR=10) and 256 (NR=14); any other value is an elaboration error
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- plain_text  input  128  plaintext block, sampled on accept
- cipher_key  input  KEY_BITS  cipher key, sampled on accept
- cipher_new_en  input  1  request strobe; accepted only when cipher_busy=0
- cipher_busy  output  1  high while rounds are in progress
- cipher_ready  output  1  cipher_text valid; held until the next accepted request
- cipher_text  output  128  ciphertext, FIPS-197 byte order (byte 0 = bits [127:120])

## Operation
- States: IDLE, ROUND, DONE. Reset: state=IDLE; cipher_busy=0, cipher_ready=0, cipher_text=0, internal state/key/round registers all 0.
- Accept: cipher_new_en=1 while in IDLE or DONE. On that edge:
  - state register <= plain_text ^ first 128 key bits.
  - Key registers load cipher_key.
  - Round counter <= 1; cipher_ready <= 0; cipher_busy <= 1; go to ROUND.
- ROUND: each edge applies SubBytes, ShiftRows, MixColumns and AddRoundKey(round key r), then increments r. MixColumns is omitted when r=NR. On the r=NR edge:
  - cipher_text <= result; cipher_ready <= 1; cipher_busy <= 0; go to DONE.
- Key schedule, AES-128: round key r = expand(key r-1, Rcon(r)); one key register.
- Key schedule, AES-256: two 128-bit key registers hold keys r-2 and r-1.
  - Round key 1 = cipher_key[127:0].
  - For r>=2, even r: RotWord, SubWord, and Rcon(r/2) applied to the last word of key r-1. Odd r: SubWord only, no Rcon.
- Boundary cases:
  - cipher_new_en during ROUND is ignored: no queuing, and the in-flight operation is not disturbed.
  - cipher_new_en in DONE starts a new operation. cipher_ready falls on that edge; cipher_text keeps the old value until the new result is written.
  - plain_text and cipher_key may change after the accept edge without effect.
  - Reset asserted mid-ROUND returns to IDLE immediately. No result is produced.
  - DONE with no new request holds all outputs indefinitely.

## Timing
- Latency: NR cycles from the accept edge to the first cycle with cipher_ready=1. That is 10 cycles for AES-128 and 14 for AES-256.
- Throughput: one block per NR+1 cycles. A new request can be presented in the first cycle cipher_ready is high.
- cipher_busy is high for exactly NR cycles per operation.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- AES_LAST_KEY_OUT_EN defined:
  - Adds output last_round_key [127:0], holding round key NR.
  - It is updated on the same edge as cipher_text and valid while cipher_ready=1.
  - Reset value is 0.
  - Purpose: supplying the decrypt-core key setup.
- AES_LAST_KEY_OUT_EN undefined: the port and its register are absent. All other behaviour is identical.

## Test plan
- KEY_BITS=128:
  - Stimulus: pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f.
  - Required response: cipher_text 69c4e0d86a7b0430d8cdb78070b4c55a with cipher_ready high 10 cycles after accept.
  - With macro defined: last_round_key 13111d7fe3944a17f307a78b4d2b30c5.
- KEY_BITS=256:
  - Stimulus: same pt, key 000102…1f.
  - Required response: 8ea2b7ca516745bfeafc49904b496089 after 14 cycles; cipher_busy high for exactly 14 cycles.
- KEY_BITS=128, all-zero pt and key:
  - Required response: 66e94bd4ef8a2c3b884cfa59ca342b2e.
  - Then, in the first DONE cycle, request pt 00112233445566778899aabbccddeeff with key a5…a5. The second result must appear 10 cycles later, and cipher_ready must be low in between.
- Pulse cipher_new_en with a different pt at round 5 -> it is ignored; the result equals the first vector.
- Assert reset at round 4 -> all outputs 0 at once. After reset release, a fresh request yields the correct vector result.
